fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter_pkg.sv | 17 +
 rtl/sync_2ff.sv | 27 ++
 rtl/fifo_write_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types, default widths and pointer encoding helper for the FIFO write arbiter.
package fifo_write_arbiter_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int ADDR_WIDTH_DEF = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_e;

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a multi-bit Gray-coded value crossing into this clock domain.
module sync_2ff #(
   parameter int WIDTH = 7
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // NOTE: non-blocking assignments so both stages sample the pre-edge values and form a true two-stage chain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Two-requester packet-locked arbiter feeding the write side of an async FIFO.
module fifo_write_arbiter
   import fifo_write_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clock_write,
   input  logic                  reset_write,
   input  logic                  req0_valid,
   input  logic [DATA_WIDTH-1:0] req0_data,
   input  logic                  req0_last,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [DATA_WIDTH-1:0] req1_data,
   input  logic                  req1_last,
   output logic                  req1_ready,
   input  logic [ADDR_WIDTH:0]   read_pointer_gray,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic [ADDR_WIDTH-1:0] write_address,
   output logic                  write_enable,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   write_pointer_gray,
   output logic [1:0]            grant
);

   localparam int PW = ADDR_WIDTH + 1;

   state_e        state_q, state_d;
   logic          last_served_q, last_served_d;
   logic [PW-1:0] wptr_bin_q, wptr_bin_d;
   logic [PW-1:0] wptr_gray_q, wptr_gray_d;
   logic [PW-1:0] rptr_sync;
   logic          sel_valid, sel_last;

   sync_2ff #(.WIDTH(PW)) u_rptr_sync (
      .clk_i (clock_write),
      .rst_i (reset_write),
      .d_i   (read_pointer_gray),
      .q_o   (rptr_sync)
   );

   // Full when the write pointer has lapped the read pointer by exactly one FIFO depth.
   assign full = (wptr_gray_q == {~rptr_sync[PW-1:PW-2], rptr_sync[PW-3:0]});

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      grant = 2'b00;
      unique case (state_q)
         LOCK0:   grant = 2'b01;
         LOCK1:   grant = 2'b10;
         default: begin
            if (req0_valid && req1_valid) grant = last_served_q ? 2'b01 : 2'b10;
            else                          grant = {req1_valid, req0_valid};
         end
      endcase
   end

   assign req0_ready = grant[0] & ~full;
   assign req1_ready = grant[1] & ~full;

   always_comb begin
      sel_valid  = 1'b0;
      sel_last   = 1'b0;
      write_data = '0;
      if (grant[0]) begin
         sel_valid  = req0_valid;
         sel_last   = req0_last;
         write_data = req0_data;
      end else if (grant[1]) begin
         sel_valid  = req1_valid;
         sel_last   = req1_last;
         write_data = req1_data;
      end
   end

   assign write_enable = sel_valid & ~full;

   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      if (write_enable) begin
         if (sel_last) begin
            state_d       = IDLE;
            last_served_d = grant[1];
         end else begin
            state_d = grant[1] ? LOCK1 : LOCK0;
         end
      end
   end

   assign wptr_bin_d  = wptr_bin_q + PW'(write_enable);
   assign wptr_gray_d = PW'(bin2gray(32'(wptr_bin_d)));

   always_ff @(posedge clock_write) begin
      if (reset_write) begin
         state_q       <= IDLE;
         last_served_q <= 1'b1;
         wptr_bin_q    <= '0;
         wptr_gray_q   <= '0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         wptr_bin_q    <= wptr_bin_d;
         wptr_gray_q   <= wptr_gray_d;
      end
   end

   assign write_address      = wptr_bin_q[ADDR_WIDTH-1:0];
   assign write_pointer_gray = wptr_gray_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and randomized checks of fifo_write_arbiter against a packet-level reference model.
module tb_fifo_write_arbiter;

   localparam int DW    = 16;
   localparam int AW    = 6;
   localparam int PW    = AW + 1;
   localparam int DEPTH = 1 << AW;
   localparam int SPAN  = 1 << PW;

   logic          clock_write = 1'b0;
   logic          reset_write;
   logic          req0_valid, req0_last, req0_ready;
   logic          req1_valid, req1_last, req1_ready;
   logic [DW-1:0] req0_data, req1_data, write_data;
   logic [PW-1:0] read_pointer_gray, write_pointer_gray;
   logic [AW-1:0] write_address;
   logic          write_enable, full;
   logic [1:0]    grant;

   fifo_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock_write        (clock_write),
      .reset_write        (reset_write),
      .req0_valid         (req0_valid),
      .req0_data          (req0_data),
      .req0_last          (req0_last),
      .req0_ready         (req0_ready),
      .req1_valid         (req1_valid),
      .req1_data          (req1_data),
      .req1_last          (req1_last),
      .req1_ready         (req1_ready),
      .read_pointer_gray  (read_pointer_gray),
      .write_data         (write_data),
      .write_address      (write_address),
      .write_enable       (write_enable),
      .full               (full),
      .write_pointer_gray (write_pointer_gray),
      .grant              (grant)
   );

   always #5 clock_write = ~clock_write;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: packet owner (-1 = none), last served requester, total words written,
   // and the read pointer values seen at each clock edge (the write side sees them two edges late).
   int            owner, last_srv, wr_total, rd_total;
   logic [PW-1:0] rp_hist[$];

   logic [1:0]    obs_grant;
   logic          obs_r0, obs_r1, obs_we;
   logic [AW-1:0] obs_addr;

   function automatic int to_gray(input int b);
      return (b ^ (b >> 1)) % SPAN;
   endfunction

   function automatic int from_gray(input int g);
      int b = g;
      for (int s = 1; s < PW; s++) b = b ^ (g >> s);
      return b % SPAN;
   endfunction

   task automatic drive(input logic v0, input logic [DW-1:0] d0, input logic l0,
                        input logic v1, input logic [DW-1:0] d1, input logic l1);
      req0_valid = v0; req0_data = d0; req0_last = l0;
      req1_valid = v1; req1_data = d1; req1_last = l1;
   endtask

   task automatic do_reset();
      reset_write = 1'b1;
      @(posedge clock_write);
      owner    = -1;
      last_srv = 1;
      wr_total = 0;
      rd_total = 0;
      rp_hist.delete();
      #1;
      reset_write = 1'b0;
   endtask

   // One clock cycle: predict and compare outputs mid-cycle, then advance the model at the edge.
   task automatic step(input string tag);
      int            g, wptr, occ;
      logic          exp_full, exp_we, g_last;
      logic [PW-1:0] seen_rp;
      @(negedge clock_write);
      seen_rp  = (rp_hist.size() >= 2) ? rp_hist[rp_hist.size()-2] : '0;
      wptr     = wr_total % SPAN;
      occ      = (wptr - from_gray(int'(seen_rp)) + SPAN) % SPAN;
      exp_full = (occ == DEPTH);
      if (owner >= 0)                    g = owner;
      else if (req0_valid && req1_valid) g = (last_srv == 1) ? 0 : 1;
      else if (req0_valid)               g = 0;
      else if (req1_valid)               g = 1;
      else                               g = -1;
      exp_we = ((g == 0 && req0_valid) || (g == 1 && req1_valid)) && !exp_full;
      g_last = (g == 1) ? req1_last : req0_last;

      check({tag, ".grant"}, 32'(grant), (g < 0) ? 32'd0 : 32'(1 << g));
      check({tag, ".ready0"}, 32'(req0_ready), 32'(g == 0 && !exp_full));
      check({tag, ".ready1"}, 32'(req1_ready), 32'(g == 1 && !exp_full));
      check({tag, ".full"}, 32'(full), 32'(exp_full));
      check({tag, ".we"}, 32'(write_enable), 32'(exp_we));
      check({tag, ".addr"}, 32'(write_address), 32'(wptr % DEPTH));
      check({tag, ".wgray"}, 32'(write_pointer_gray), 32'(to_gray(wptr)));
      if (exp_we)      check({tag, ".data"}, 32'(write_data), 32'((g == 1) ? req1_data : req0_data));
      else if (g < 0)  check({tag, ".data0"}, 32'(write_data), 32'd0);

      obs_grant = grant;
      obs_r0    = req0_ready;
      obs_r1    = req1_ready;
      obs_we    = write_enable;
      obs_addr  = write_address;

      @(posedge clock_write);
      rp_hist.push_back(read_pointer_gray);
      if (rp_hist.size() > 4) void'(rp_hist.pop_front());
      if (exp_we) begin
         wr_total++;
         if (g_last) begin
            owner    = -1;
            last_srv = g;
         end else begin
            owner = g;
         end
      end
      #1;
   endtask

   initial begin
      logic [1:0] alt[4];
      alt = '{2'b01, 2'b10, 2'b01, 2'b10};
      drive(0, '0, 0, 0, '0, 0);
      read_pointer_gray = '0;
      do_reset();

      // Reset state with no requests.
      step("reset");
      check("reset.full", 32'(full), 32'd0);

      // First single-beat write lands at address 0, pointer advances to 1.
      drive(1, 16'hA5A5, 1, 0, '0, 0);
      step("first");
      check("first.we", 32'(obs_we), 32'd1);
      check("first.addr", 32'(obs_addr), 32'd0);
      check("first.wgray_after", 32'(write_pointer_gray), 32'(7'b0000001));

      // Single-beat ties alternate, starting from the requester not served last.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 16'(16'h1000 + i), 1, 1, 16'(16'h2000 + i), 1);
         step("tie");
         check("tie.alt", 32'(obs_grant), 32'(alt[i]));
      end

      // req0 three-beat packet holds off req1 until its last beat.
      for (int i = 0; i < 3; i++) begin
         drive(1, 16'(16'h3000 + i), (i == 2), 1, 16'h4444, 1);
         step("lock0");
         check("lock0.r1_blocked", 32'(obs_r1), 32'd0);
      end
      drive(1, 16'h3333, 1, 1, 16'h4444, 1);
      step("after_lock0");
      check("after_lock0.grant", 32'(obs_grant), 32'd2);

      // Fill to full with a stationary reader, then show backpressure.
      do_reset();
      read_pointer_gray = '0;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 16'(i), 1, 0, '0, 0);
         step("fill");
      end
      check("fill.full", 32'(full), 32'd1);
      check("fill.wgray", 32'(write_pointer_gray), 32'(7'b1100000));
      drive(1, 16'hBEEF, 1, 0, '0, 0);
      step("fullhold");
      check("fullhold.ready0", 32'(obs_r0), 32'd0);
      check("fullhold.we", 32'(obs_we), 32'd0);

      // Reader frees one entry; full drops after the synchronizer delay.
      read_pointer_gray = 7'b0000001;
      step("drain1");
      step("drain2");
      step("drain3");
      check("drain3.we", 32'(obs_we), 32'd1);
      check("drain3.addr", 32'(obs_addr), 32'd0);

      // Reset during a req1 packet abandons the lock and restores req0 tie priority.
      do_reset();
      read_pointer_gray = '0;
      drive(0, '0, 0, 1, 16'h5151, 0);
      step("lock1_a");
      drive(1, 16'h0F0F, 0, 1, 16'h5252, 0);
      step("lock1_b");
      check("lock1_b.grant", 32'(obs_grant), 32'd2);
      do_reset();
      drive(1, 16'h6060, 1, 1, 16'h6161, 1);
      step("post_reset");
      check("post_reset.grant", 32'(obs_grant), 32'd1);

      // Randomized traffic with a reader that drains slowly, then quickly.
      do_reset();
      read_pointer_gray = '0;
      for (int c = 0; c < 3000; c++) begin
         drive(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 3) == 0));
         step("rand");
         if (rd_total < wr_total && $urandom_range(0, (c < 1500) ? 5 : 1) == 0) rd_total++;
         read_pointer_gray = PW'(to_gray(rd_total % SPAN));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
